p1_sprite_renderer: RTL

- Pixel-pipeline stage that sits directly upstream of the player-1 sprite ROMs (128x128, 12-bit RGB 4:4:4, 1-cycle registered read).
- Converts VGA raster coordinates and the player's on-screen position into a 14-bit ROM address and a ROM bank select.
- Consumes the returned pixel, applies colour-key transparency over a background colour, and emits a timing-aligned RGB pixel to the VGA output mux.
- Latches position, pose and facing once per frame, so the sprite never tears mid-frame.

---
 rtl/p1_sprite_renderer_if.sv | 36 +++
 rtl/p1_sprite_renderer.sv | 90 +++++++++
 2 files changed

// File: rtl/p1_sprite_renderer_if.sv
// Raster, position, sprite-ROM and pixel-output signals of the player-1 sprite renderer.
// With SPRITE_MIRROR_EN defined the bundle also carries facing_left.
interface p1_sprite_renderer_if;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        frame_start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [1:0]  pose_sel;
`ifdef SPRITE_MIRROR_EN
  logic        facing_left;
`endif
  logic [13:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic        sprite_hit;
  logic        video_on_d;

  modport slave (
`ifdef SPRITE_MIRROR_EN
    input  facing_left,
`endif
    input  hcount, vcount, video_on, frame_start, pos_x, pos_y, pose_sel, rom_data,
    output rom_addr, rom_sel, rgb, sprite_hit, video_on_d
  );

  modport master (
`ifdef SPRITE_MIRROR_EN
    output facing_left,
`endif
    output hcount, vcount, video_on, frame_start, pos_x, pos_y, pose_sel, rom_data,
    input  rom_addr, rom_sel, rgb, sprite_hit, video_on_d
  );
endinterface

// File: rtl/p1_sprite_renderer.sv
// Player-1 sprite pipeline: raster -> ROM address, then colour-key over background, 3-cycle latency.
// Optional horizontal flip via facing_left when SPRITE_MIRROR_EN is defined.
module p1_sprite_renderer #(
  parameter int          SPR_W     = 128,
  parameter int          SPR_H     = 128,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [9:0]  INIT_X    = 10'd64,
  parameter logic [9:0]  INIT_Y    = 10'd300
) (
  input  logic                  clk,
  input  logic                  rst_n,
  p1_sprite_renderer_if.slave   bus
);
  localparam int AW = $clog2(SPR_W);
  localparam int AH = $clog2(SPR_H);

  logic [9:0]  x_q, y_q;
  logic [1:0]  pose_q;
  logic        facing_q;
  logic [13:0] rom_addr_q, rom_addr_d;
  logic [1:0]  rom_sel_q;
  logic        in_box_d1_q, von_d1_q, in_box_d2_q, von_d2_q;
  logic [11:0] rgb_q;
  logic        hit_q, von_d_q;

  logic [10:0]   hc, vc, xe, ye, dx, dy;
  logic          in_box, opaque;
  logic [AW-1:0] dx_eff;

  // 11-bit arithmetic keeps x_l+SPR_W from wrapping past 1023.
  always_comb begin
    hc     = {1'b0, bus.hcount};
    vc     = {1'b0, bus.vcount};
    xe     = {1'b0, x_q};
    ye     = {1'b0, y_q};
    dx     = hc - xe;
    dy     = vc - ye;
    in_box = bus.video_on && (hc >= xe) && (hc < xe + 11'(SPR_W))
                          && (vc >= ye) && (vc < ye + 11'(SPR_H));
    dx_eff = facing_q ? ~dx[AW-1:0] : dx[AW-1:0];
    rom_addr_d = in_box ? 14'({dy[AH-1:0], dx_eff}) : '0;
    opaque = in_box_d2_q && (bus.rom_data != KEY_COLOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= INIT_X;
      y_q         <= INIT_Y;
      pose_q      <= '0;
      facing_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      in_box_d1_q <= 1'b0;
      von_d1_q    <= 1'b0;
      in_box_d2_q <= 1'b0;
      von_d2_q    <= 1'b0;
      rgb_q       <= '0;
      hit_q       <= 1'b0;
      von_d_q     <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        x_q    <= bus.pos_x;
        y_q    <= bus.pos_y;
        pose_q <= bus.pose_sel;
`ifdef SPRITE_MIRROR_EN
        facing_q <= bus.facing_left;
`else
        facing_q <= 1'b0;
`endif
      end
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= pose_q;
      in_box_d1_q <= in_box;
      von_d1_q    <= bus.video_on;
      // ROM registers its word here; only the qualifiers need delaying.
      in_box_d2_q <= in_box_d1_q;
      von_d2_q    <= von_d1_q;
      rgb_q       <= !von_d2_q ? 12'h000 : (opaque ? bus.rom_data : BG_COLOR);
      hit_q       <= opaque;
      von_d_q     <= von_d2_q;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_sel    = rom_sel_q;
  assign bus.rgb        = rgb_q;
  assign bus.sprite_hit = hit_q;
  assign bus.video_on_d = von_d_q;
endmodule
